// File: rtl/bias_buf_pkg.sv
// Shared types and defaults for the ping-pong bias buffer.
package bias_buf_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_BUS_W  = 64;
  localparam int DEF_DEPTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  // A zero or oversized request means "fill the whole bank".
  function automatic int clamp_target(input int cnt, input int depth);
    return ((cnt == 0) || (cnt > depth)) ? depth : cnt;
  endfunction

endpackage

// File: rtl/bias_bank.sv
// One bias bank: DEPTH x DATA_W registers, PACK-lane masked write, combinational read.
module bias_bank
  import bias_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PACK   = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [PACK-1:0]        wr_mask,
  input  logic [PACK*DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Each entry captures the enabled lane whose offset from wr_addr lands on it
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      for (int k = 0; k < PACK; k++) begin
        if (wr_en && wr_mask[k] && ((int'(wr_addr) + k) == e)) begin
          mem_r[e] <= wr_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Indices past the bank read as zero
  always_comb begin
    rd_data = {DATA_W{1'b0}};
    if (int'(rd_addr) < DEPTH) begin
      rd_data = mem_r[rd_addr];
    end else begin
      rd_data = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/bias_buf_pp.sv
// Double-buffered bias store: streaming load into the shadow bank, single-bias
// reads from the active bank, controller-driven swap.
module bias_buf_pp
  import bias_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BUS_W  = DEF_BUS_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int PACK   = BUS_W / DATA_W,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [CNT_W-1:0]  load_cnt,
  input  logic              in_valid,
  input  logic [BUS_W-1:0]  in_data,
  output logic              in_ready,
  output logic              load_done,
  output logic              shadow_full,
  input  logic              swap,
  output logic              swap_err,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              active_bank
);

  // Pointer must hold one step past the last beat without wrapping.
  localparam int PTR_W = $clog2(DEPTH + PACK + 1);

  state_e            state_r;
  state_e            next_state_s;
  logic [PTR_W-1:0]  ptr_r;
  logic [PTR_W-1:0]  next_ptr_s;
  logic [CNT_W-1:0]  target_r;
  logic              active_bank_r;
  logic              load_done_r;
  logic              swap_err_r;
  logic              rd_valid_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              in_ready_s;
  logic              shadow_full_s;
  logic              beat_s;
  logic              last_beat_s;
  logic              swap_ok_s;
  logic [PACK-1:0]   lane_mask_s;
  logic [1:0]        bank_we_s;
  logic [DATA_W-1:0] bank_rd_s [2];

  assign beat_s      = in_valid && in_ready_s;
  assign next_ptr_s  = ptr_r + PTR_W'(PACK);
  assign last_beat_s = beat_s && (next_ptr_s >= PTR_W'(target_r));
  assign swap_ok_s   = swap && (state_r == ST_FULL);

  // The shadow bank is always the one not being read.
  assign bank_we_s[0] = beat_s && active_bank_r;
  assign bank_we_s[1] = beat_s && !active_bank_r;

  // Lanes at or beyond the target count are dropped
  always_comb begin
    lane_mask_s = {PACK{1'b0}};
    for (int k = 0; k < PACK; k++) begin
      lane_mask_s[k] = (int'(ptr_r) + k) < int'(target_r);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state; load_start outside IDLE is ignored, swap wins in FULL
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: if (load_start) next_state_s = ST_LOAD; else next_state_s = ST_IDLE;
      ST_LOAD: if (last_beat_s) next_state_s = ST_FULL; else next_state_s = ST_LOAD;
      ST_FULL: if (swap) next_state_s = ST_IDLE; else next_state_s = ST_FULL;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register
  always_comb begin
    in_ready_s    = 1'b0;
    shadow_full_s = 1'b0;
    case (state_r)
      ST_IDLE: in_ready_s = 1'b0;
      ST_LOAD: in_ready_s = 1'b1;
      ST_FULL: shadow_full_s = 1'b1;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Load pointer and target count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r    <= {PTR_W{1'b0}};
      target_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_IDLE) && load_start) begin
      ptr_r    <= {PTR_W{1'b0}};
      target_r <= CNT_W'(clamp_target(int'(load_cnt), DEPTH));
    end else if (beat_s) begin
      ptr_r <= next_ptr_s;
    end
  end

  // Bank select and one-cycle status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_bank_r <= 1'b0;
      load_done_r   <= 1'b0;
      swap_err_r    <= 1'b0;
    end else begin
      active_bank_r <= active_bank_r ^ swap_ok_s;
      load_done_r   <= last_beat_s;
      swap_err_r    <= swap && (state_r != ST_FULL);
    end
  end

  // Read register samples the pre-swap active bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r  <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) begin
        rd_data_r <= bank_rd_s[active_bank_r];
      end
    end
  end

  bias_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PACK(PACK)) u_bank0 (
    .clk     (clk),
    .wr_en   (bank_we_s[0]),
    .wr_addr (ptr_r[ADDR_W-1:0]),
    .wr_mask (lane_mask_s),
    .wr_data (in_data),
    .rd_addr (rd_idx),
    .rd_data (bank_rd_s[0])
  );

  bias_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PACK(PACK)) u_bank1 (
    .clk     (clk),
    .wr_en   (bank_we_s[1]),
    .wr_addr (ptr_r[ADDR_W-1:0]),
    .wr_mask (lane_mask_s),
    .wr_data (in_data),
    .rd_addr (rd_idx),
    .rd_data (bank_rd_s[1])
  );

  assign in_ready    = in_ready_s;
  assign shadow_full = shadow_full_s;
  assign load_done   = load_done_r;
  assign swap_err    = swap_err_r;
  assign rd_data     = rd_data_r;
  assign rd_valid    = rd_valid_r;
  assign active_bank = active_bank_r;

endmodule

// File: doc/bias_buf_pp.md
Name: bias_buf_pp

Overview:
- Parametrised, double-buffered (ping-pong) bias buffer for the conv/FC datapath.
- A streaming valid/ready load path fills the shadow bank with packed bias words; the PE array reads single biases from the active bank.
- A controller-issued swap exchanges the banks, so the next layer's biases load while the current layer computes.

Parameters:
- DATA_W, 16: bias element width.
- BUS_W, 64: load bus width. Must be an integer multiple of DATA_W.
- DEPTH, 8: entries per bank. Must be at least PACK.
- Derived (localparam, not overridable): PACK = BUS_W/DATA_W; ADDR_W = $clog2(DEPTH); CNT_W = $clog2(DEPTH+1).

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- load_start, input, 1: pulse; begins a shadow-bank load.
- load_cnt, input, CNT_W: number of entries to load. Sampled with load_start.
- in_valid, input, 1: load beat valid.
- in_data, input, BUS_W: packed biases; lane k is bits [k*DATA_W +: DATA_W].
- in_ready, output, 1: load beat accepted when in_valid & in_ready.
- load_done, output, 1: one-cycle pulse when the shadow bank is complete.
- shadow_full, output, 1: high while the shadow bank holds a completed load that has not yet been swapped.
- swap, input, 1: pulse; promotes the shadow bank to active.
- swap_err, output, 1: one-cycle pulse when swap is issued while not FULL.
- rd_en, input, 1: read request.
- rd_idx, input, ADDR_W: entry index in the active bank.
- rd_data, output, DATA_W: registered read data.
- rd_valid, output, 1: one-cycle pulse qualifying rd_data.
- active_bank, output, 1: current active bank select.

Behaviour:
- Reset values (asynchronous): FSM state IDLE, active_bank = 0, load pointer = 0, target = 0. Outputs: in_ready = 0, load_done = 0, shadow_full = 0, swap_err = 0, rd_data = 0, rd_valid = 0.
- Bank storage is not reset. Read data is undefined until the first load followed by a swap.
- FSM states:
  - IDLE. in_ready = 0. On load_start: ptr <= 0; target <= (load_cnt == 0 || load_cnt > DEPTH) ? DEPTH : load_cnt; go to LOAD.
  - LOAD. in_ready = 1. On each accepted beat, write lane k to shadow[ptr+k] for every k with ptr+k < target; lanes at or beyond target are dropped. Then ptr <= ptr + PACK. If ptr + PACK >= target: go to FULL and pulse load_done in the next cycle. in_ready drops in the cycle after the final beat.
  - FULL. in_ready = 0, shadow_full = 1. On swap: active_bank toggles, go to IDLE. Writes never touch the active bank.
- load_start in LOAD or FULL: ignored; no state change and the pointer is unchanged.
- swap in IDLE or LOAD: no bank change; swap_err pulses the next cycle.
- swap and load_start in the same cycle while in FULL: the swap is taken and load_start is ignored. The controller must reissue load_start after the swap.
- Read path:
  - Latency is one cycle. If rd_en is sampled at edge N, then rd_data and rd_valid are valid after edge N, with rd_valid = 1 for one cycle.
  - rd_idx >= DEPTH returns rd_data = 0 with rd_valid = 1.
  - Without rd_en: rd_valid = 0 and rd_data holds its last value.
  - rd_en in the same cycle as an accepted swap reads the pre-swap active bank.
- Back-to-back reads: one per cycle, full throughput.
- Reset mid-load: the FSM returns to IDLE and the partial shadow contents are abandoned. active_bank returns to 0.

Decomposition:
- Shared package bias_buf_pkg holds the FSM state enum (IDLE, LOAD, FULL) and the default DATA_W/BUS_W/DEPTH constants.
- One sub-module, bias_bank: a DEPTH x DATA_W register array with a PACK-lane masked write port and one combinational read port, instantiated twice.
- The top level holds the FSM, pointer, bank select and read register.

Test Plan:
1. Reset, then load_start with load_cnt = 8; two beats 0x0004_0003_0002_0001 and 0x0008_0007_0006_0005; then swap; then read idx 0..7 back-to-back -> load_done one cycle after beat 2; rd_data = 1..8 one cycle after each rd_en; active_bank = 1.
2. Partial load: load_cnt = 6; beats as in test 1; swap -> entries 6 and 7 keep their prior-bank contents (never written); reads of 0..5 return 1..6; FULL is reached after beat 2.
3. Ping-pong: with bank 1 active holding 1..8, load 0x00AA lanes into bank 0 while issuing continuous reads -> reads return 1..8 until swap; the first read after swap returns 0x00AA.
4. swap issued in IDLE and again mid-LOAD -> swap_err pulses twice; active_bank unchanged; the load completes normally.
5. rd_idx = 9 with DEPTH = 8 overridden to DEPTH = 10, plus rd_idx = 12 -> idx 9 returns loaded data; idx 12 returns 0 with rd_valid = 1.
6. Assert rst after 1 of 2 beats -> in_ready = 0 and shadow_full = 0 immediately, state IDLE, active_bank = 0; a new load_start is accepted on the first cycle after rst drops.
